// File: rtl/snax_simbacore_csr_ctrl_pkg.sv
// Shared types and constants for the SimbaCore CSR launch controller.
// Optional feature macro: SNAX_SIMBACORE_CSR_TIMEOUT_EN (WAIT_BUSY watchdog).
package snax_simbacore_csr_pkg;

    localparam int unsigned DefRegRWCount    = 6;
    localparam int unsigned DefRegROCount    = 4;
    localparam int unsigned DefRegDataWidth  = 32;
    localparam int unsigned DefNumModes      = 4;
    localparam int unsigned DefTimeoutCycles = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        RUN
    } state_e;

    // RW CSR word indices
    localparam int unsigned ModeIdx   = 0;
    localparam int unsigned SeqLenIdx = 1;
    localparam int unsigned DModelIdx = 2;
    localparam int unsigned DtRankIdx = 3;
    localparam int unsigned DInnerIdx = 4;
    localparam int unsigned StartIdx  = 5;

    // RO CSR word indices
    localparam int unsigned StatusIdx = 0;
    localparam int unsigned PerfIdx   = 1;
    localparam int unsigned LaunchIdx = 2;
    localparam int unsigned ErrIdx    = 3;

    // Status word bit positions
    localparam int unsigned BusyBit    = 0;
    localparam int unsigned ErrBit     = 1;
    localparam int unsigned TimeoutBit = 2;

    // A launch is legal only with a known mode and non-empty sequence/model dims.
    function automatic logic cfg_legal(
        input logic [DefRegDataWidth-1:0] mode,
        input logic [DefRegDataWidth-1:0] seq_len,
        input logic [DefRegDataWidth-1:0] d_model,
        input int unsigned                num_modes
    );
        return (mode < DefRegDataWidth'(num_modes)) && (seq_len != '0) && (d_model != '0);
    endfunction

endpackage

// File: rtl/snax_simbacore_csr_ctrl_if.sv
// CSR manager / SimbaCore config bus bundle for the launch controller.
// master: CSR manager + core side; slave: the controller.
interface snax_simbacore_csr_ctrl_if #(
    parameter int unsigned RegRWCount   = snax_simbacore_csr_pkg::DefRegRWCount,
    parameter int unsigned RegROCount   = snax_simbacore_csr_pkg::DefRegROCount,
    parameter int unsigned RegDataWidth = snax_simbacore_csr_pkg::DefRegDataWidth
);

    logic [RegRWCount*RegDataWidth-1:0] csr_reg_set;
    logic                               csr_reg_set_valid;
    logic                               csr_reg_set_ready;
    logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set;

    logic                               cfg_valid;
    logic                               cfg_ready;
    logic [RegDataWidth-1:0]            cfg_mode;
    logic [RegDataWidth-1:0]            cfg_seq_len;
    logic [RegDataWidth-1:0]            cfg_d_model;
    logic [RegDataWidth-1:0]            cfg_dt_rank;
    logic [RegDataWidth-1:0]            cfg_d_inner;

    logic                               core_busy;

    modport master (
        output csr_reg_set, csr_reg_set_valid, cfg_ready, core_busy,
        input  csr_reg_set_ready, csr_reg_ro_set, cfg_valid,
               cfg_mode, cfg_seq_len, cfg_d_model, cfg_dt_rank, cfg_d_inner
    );

    modport slave (
        input  csr_reg_set, csr_reg_set_valid, cfg_ready, core_busy,
        output csr_reg_set_ready, csr_reg_ro_set, cfg_valid,
               cfg_mode, cfg_seq_len, cfg_d_model, cfg_dt_rank, cfg_d_inner
    );

endinterface

// File: rtl/snax_simbacore_csr_ctrl_sat_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
module snax_simbacore_sat_counter #(
    parameter int unsigned Width    = 32,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [Width-1:0] count
);

    // Clear wins over enable; saturating instances stop at all-ones, others wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !(Saturate && (count == '1))) begin
            count <= count + Width'(1);
        end
    end

endmodule

// File: rtl/snax_simbacore_csr_ctrl.sv
// Launch controller between the SNAX CSR manager and the SimbaCore config port.
// Latches CSR writes, validates launches, performs one config handshake per
// launch and tracks core busy to completion. Status/perf/launch/error are RO.
// Optional feature macro: SNAX_SIMBACORE_CSR_TIMEOUT_EN (WAIT_BUSY watchdog).
module snax_simbacore_csr_ctrl
    import snax_simbacore_csr_pkg::*;
#(
    parameter int unsigned RegRWCount    = DefRegRWCount,
    parameter int unsigned RegROCount    = DefRegROCount,
    parameter int unsigned RegDataWidth  = DefRegDataWidth,
    parameter int unsigned NumModes      = DefNumModes,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input logic                      clk_i,
    input logic                      rst_i,
    snax_simbacore_csr_ctrl_if.slave bus
);

    state_e                  state;
    logic                    cfg_valid_q;
    logic [RegDataWidth-1:0] mode_q, seq_len_q, d_model_q, dt_rank_q, d_inner_q;
    logic                    err_q;

    logic [RegDataWidth-1:0] word [RegRWCount];
    logic                    csr_fire;
    logic                    start;
    logic                    legal;
    logic                    launch_fire;
    logic                    err_fire;
    logic                    cfg_fire;
    logic                    timeout_fire;
    logic [RegDataWidth-1:0] status;
    logic [RegDataWidth-1:0] perf_cnt, launch_cnt, err_cnt;
    logic                    unused_start_bits;

`ifdef SNAX_SIMBACORE_CSR_TIMEOUT_EN
    logic [15:0]             wd_q;
    logic                    to_q;
`endif

    // Split the flat CSR bus into words.
    always_comb begin
        for (int unsigned i = 0; i < RegRWCount; i++) begin
            word[i] = bus.csr_reg_set[i*RegDataWidth +: RegDataWidth];
        end
    end

    assign unused_start_bits = ^word[StartIdx][RegDataWidth-1:1];

    assign bus.csr_reg_set_ready = (state == IDLE);
    assign csr_fire    = bus.csr_reg_set_valid && (state == IDLE);
    assign start       = word[StartIdx][0];
    assign legal       = cfg_legal(word[ModeIdx], word[SeqLenIdx], word[DModelIdx], NumModes);
    assign launch_fire = csr_fire && start && legal;
    assign err_fire    = csr_fire && start && !legal;
    assign cfg_fire    = (state == ISSUE) && cfg_valid_q && bus.cfg_ready;

`ifdef SNAX_SIMBACORE_CSR_TIMEOUT_EN
    assign timeout_fire = (state == WAIT_BUSY) && !bus.core_busy
                          && (wd_q == 16'(TimeoutCycles - 1));
`else
    assign timeout_fire = 1'b0;
`endif

    // Launch FSM with registered config handshake, shadow regs and sticky error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cfg_valid_q <= 1'b0;
            mode_q      <= '0;
            seq_len_q   <= '0;
            d_model_q   <= '0;
            dt_rank_q   <= '0;
            d_inner_q   <= '0;
            err_q       <= 1'b0;
`ifdef SNAX_SIMBACORE_CSR_TIMEOUT_EN
            wd_q        <= '0;
            to_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (csr_fire) begin
                        mode_q    <= word[ModeIdx];
                        seq_len_q <= word[SeqLenIdx];
                        d_model_q <= word[DModelIdx];
                        dt_rank_q <= word[DtRankIdx];
                        d_inner_q <= word[DInnerIdx];
                        if (launch_fire) begin
                            state       <= ISSUE;
                            cfg_valid_q <= 1'b1;
                            err_q       <= 1'b0;
`ifdef SNAX_SIMBACORE_CSR_TIMEOUT_EN
                            to_q        <= 1'b0;
`endif
                        end else if (err_fire) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (cfg_fire) begin
                        state       <= WAIT_BUSY;
                        cfg_valid_q <= 1'b0;
`ifdef SNAX_SIMBACORE_CSR_TIMEOUT_EN
                        wd_q        <= '0;
`endif
                    end
                end
                WAIT_BUSY: begin
                    if (bus.core_busy) begin
                        state <= RUN;
`ifdef SNAX_SIMBACORE_CSR_TIMEOUT_EN
                    end else if (timeout_fire) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                        to_q  <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 16'd1;
`endif
                    end
                end
                RUN: begin
                    if (!bus.core_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cfg_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_valid   = cfg_valid_q;
    assign bus.cfg_mode    = mode_q;
    assign bus.cfg_seq_len = seq_len_q;
    assign bus.cfg_d_model = d_model_q;
    assign bus.cfg_dt_rank = dt_rank_q;
    assign bus.cfg_d_inner = d_inner_q;

    // Perf restarts on each legal launch and is frozen while idle.
    snax_simbacore_sat_counter #(
        .Width    (RegDataWidth),
        .Saturate (1'b1)
    ) u_perf_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (launch_fire),
        .en    (state != IDLE),
        .count (perf_cnt)
    );

    snax_simbacore_sat_counter #(
        .Width    (RegDataWidth),
        .Saturate (1'b0)
    ) u_launch_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (1'b0),
        .en    (cfg_fire),
        .count (launch_cnt)
    );

    snax_simbacore_sat_counter #(
        .Width    (RegDataWidth),
        .Saturate (1'b0)
    ) u_err_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (1'b0),
        .en    (err_fire || timeout_fire),
        .count (err_cnt)
    );

    // Assemble the status word and the flat RO CSR bus.
    always_comb begin
        status          = '0;
        status[BusyBit] = (state != IDLE);
        status[ErrBit]  = err_q;
`ifdef SNAX_SIMBACORE_CSR_TIMEOUT_EN
        status[TimeoutBit] = to_q;
`endif
        bus.csr_reg_ro_set = '0;
        bus.csr_reg_ro_set[StatusIdx*RegDataWidth +: RegDataWidth] = status;
        bus.csr_reg_ro_set[PerfIdx*RegDataWidth   +: RegDataWidth] = perf_cnt;
        bus.csr_reg_ro_set[LaunchIdx*RegDataWidth +: RegDataWidth] = launch_cnt;
        bus.csr_reg_ro_set[ErrIdx*RegDataWidth    +: RegDataWidth] = err_cnt;
    end

endmodule
